// File: rtl/qed_mem_scan_ctrl_if.sv
// Shared read-port bundle between core, QED scanner and data memory.
// master: scan controller side; slave: core/memory side.
interface qed_mem_scan_ctrl_if #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32,
    localparam int ADDR_W = $clog2(DEPTH)
);
    logic              core_req;
    logic [ADDR_W-1:0] core_addr;
    logic              core_gnt;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        input  core_req,
        input  core_addr,
        output core_gnt,
        output rd_en,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        output core_req,
        output core_addr,
        input  core_gnt,
        input  rd_en,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/qed_mem_scan_ctrl.sv
// QED post-commit scan: compares memory word j against j+DEPTH/2 over a shared port.
// Optional QED_SCAN_EARLY_EXIT_EN: stop the scan at the first mismatching pair.
module qed_mem_scan_ctrl #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    qed_mem_scan_ctrl_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                mismatch_valid,
    output logic [ADDR_W-2:0]   mismatch_idx,
    output logic [ADDR_W-1:0]   mismatch_cnt
);
    localparam int IW = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] CNT_MAX  = ADDR_W'(DEPTH / 2);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DEPTH / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_O,
        S_WAIT_O,
        S_ISSUE_D,
        S_WAIT_D,
        S_DONE
    } state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] orig_q;
    logic [ADDR_W-1:0] addr_q;
    logic              scan_rd;
    logic [ADDR_W-1:0] scan_addr;
    logic              miss;
    logic              last;

    // Duplicate half starts at DEPTH/2, so its address is idx with the MSB set.
    always_comb begin
        scan_rd   = 1'b0;
        scan_addr = addr_q;
        if (!bus.core_req) begin
            if (state == S_ISSUE_O) begin
                scan_rd   = 1'b1;
                scan_addr = {1'b0, idx};
            end else if (state == S_ISSUE_D) begin
                scan_rd   = 1'b1;
                scan_addr = {1'b1, idx};
            end
        end
    end

    assign bus.core_gnt = bus.core_req;
    assign bus.rd_en    = bus.core_req | scan_rd;
    assign bus.rd_addr  = bus.core_req ? bus.core_addr : scan_addr;

    assign miss = (bus.rd_data != orig_q);
    assign last = (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            idx            <= '0;
            orig_q         <= '0;
            addr_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_valid <= 1'b0;
            mismatch_idx   <= '0;
            mismatch_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (bus.rd_en) begin
                addr_q <= bus.rd_addr;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        pass           <= 1'b0;
                        mismatch_valid <= 1'b0;
                        mismatch_idx   <= '0;
                        mismatch_cnt   <= '0;
                        idx            <= '0;
                        busy           <= 1'b1;
                        state          <= S_ISSUE_O;
                    end
                end
                S_ISSUE_O: begin
                    if (!bus.core_req) begin
                        state <= S_WAIT_O;
                    end
                end
                S_WAIT_O: begin
                    orig_q <= bus.rd_data;
                    state  <= S_ISSUE_D;
                end
                S_ISSUE_D: begin
                    if (!bus.core_req) begin
                        state <= S_WAIT_D;
                    end
                end
                S_WAIT_D: begin
                    if (miss) begin
                        if (mismatch_cnt != CNT_MAX) begin
                            mismatch_cnt <= mismatch_cnt + 1'b1;
                        end
                        if (!mismatch_valid) begin
                            mismatch_idx   <= idx;
                            mismatch_valid <= 1'b1;
                        end
                    end
`ifdef QED_SCAN_EARLY_EXIT_EN
                    if (miss || last) begin
`else
                    if (last) begin
`endif
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_ISSUE_O;
                    end
                end
                S_DONE: begin
                    pass  <= !mismatch_valid;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qed_mem_scan_ctrl.sv
// Self-checking bench for qed_mem_scan_ctrl with a pair-level reference model.
module tb_qed_mem_scan_ctrl;
    localparam int DEPTH  = 32;
    localparam int DATA_W = 32;
    localparam int AW     = $clog2(DEPTH);
    localparam int H      = DEPTH / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          pass;
    logic          mv;
    logic [AW-2:0] mi;
    logic [AW-1:0] mc;

    qed_mem_scan_ctrl_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    qed_mem_scan_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mismatch_valid (mv),
        .mismatch_idx   (mi),
        .mismatch_cnt   (mc)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int total = 0;
    int bad   = 0;

    int e_lat;
    int e_idx;
    int e_cnt;
    bit e_pass;
    bit e_mv;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_consistent();
        for (int j = 0; j < H; j++) begin
            mem[j]     = $urandom;
            mem[j + H] = mem[j];
        end
    endtask

    task automatic corrupt(input int j);
        mem[j + H] = ~mem[j];
    endtask

    // Expected results straight from the pairwise comparison rule.
    task automatic model();
        int first;
        int cnt;
        first = -1;
        cnt   = 0;
        for (int j = 0; j < H; j++) begin
            if (mem[j] !== mem[j + H]) begin
                cnt++;
                if (first < 0) first = j;
            end
        end
        e_lat = 4 * H + 1;
`ifdef QED_SCAN_EARLY_EXIT_EN
        if (first >= 0) begin
            cnt   = 1;
            e_lat = 4 * (first + 1) + 1;
        end
`endif
        e_pass = (first < 0);
        e_mv   = (first >= 0);
        e_idx  = (first < 0) ? 0 : first;
        e_cnt  = cnt;
    endtask

    // mode 0: quiet, 1: random core traffic, 2: 5 stalls in ISSUE_D idx 0,
    // 3: second start at cycle 20
    task automatic scan(input int mode, input string tag);
        int cyc;
        int extra;
        int bound;
        bit seen;
        model();
        extra = (mode == 2) ? 5 : 0;
        bound = (mode == 1) ? 3 * e_lat + 20 : e_lat + extra + 20;
        start = 1'b1;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < bound) begin
            tick();
            cyc++;
            start = (mode == 3 && cyc == 20);
            if (mode == 1)
                bus.core_req = ($urandom_range(0, 3) == 0);
            else
                bus.core_req = (mode == 2 && cyc >= 3 && cyc <= 7);
            bus.core_addr = AW'($urandom);
            #1;
            if (bus.core_req) begin
                chk({tag, " gnt"}, bus.core_gnt, 1'b1);
                chk({tag, " rd_en"}, bus.rd_en, 1'b1);
                chk({tag, " rd_addr"}, bus.rd_addr, bus.core_addr);
            end
            if (done) seen = 1'b1;
        end
        bus.core_req = 1'b0;
        start        = 1'b0;
        if (mode == 1)
            chk({tag, " done_seen"}, seen, 1'b1);
        else
            chk({tag, " latency"}, cyc, e_lat + extra);
        tick();
        chk({tag, " busy_after"}, busy, 1'b0);
        chk({tag, " done_once"}, done, 1'b0);
        chk({tag, " pass"}, pass, e_pass);
        chk({tag, " mvalid"}, mv, e_mv);
        chk({tag, " midx"}, mi, e_idx);
        chk({tag, " mcnt"}, mc, e_cnt);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " pass"}, pass, 1'b0);
        chk({tag, " mvalid"}, mv, 1'b0);
        chk({tag, " midx"}, mi, 0);
        chk({tag, " mcnt"}, mc, 0);
        chk({tag, " rd_en"}, bus.rd_en, 1'b0);
        chk({tag, " rd_addr"}, bus.rd_addr, 0);
        chk({tag, " gnt"}, bus.core_gnt, 1'b0);
    endtask

    initial begin
        bit saw_done;
        rst           = 1'b1;
        start         = 1'b0;
        bus.core_req  = 1'b0;
        bus.core_addr = '0;
        fill_consistent();
        repeat (3) tick();
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        fill_consistent();
        scan(0, "clean");

        fill_consistent();
        corrupt(3);
        corrupt(9);
        scan(0, "mis3_9");

        scan(2, "contend");

        fill_consistent();
        scan(3, "restart");

        // Abort mid-scan with a mismatch already recorded.
        fill_consistent();
        corrupt(3);
        start    = 1'b1;
        saw_done = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            start = 1'b0;
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        tick();
        #1;
        chk_reset_outputs("midrst");
        rst = 1'b0;
        repeat (3) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("midrst no_done", saw_done, 1'b0);
        scan(0, "after_rst");

        fill_consistent();
        for (int j = 0; j < H; j++) corrupt(j);
        scan(0, "all_mis");

        for (int r = 0; r < 6; r++) begin
            fill_consistent();
            for (int j = 0; j < H; j++) begin
                if ($urandom_range(0, 5) == 0) mem[j + H] = mem[j] ^ 32'h0001_0000;
            end
            scan(r % 2, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
